voice_phasor_scheduler: RTL and testbench

Time-multiplexed phase-accumulator sequencer. It shares one phase-increment datapath among NUM_VOICES synthesizer voices, so a single wavetable lookup path serves all of them. On each sample tick it sweeps the voices in index order. For every gated voice it emits a registered wavetable address and interpolation fraction, then advances that voice's stored phase. It sits between the note/voice configuration logic and the wavetable/interpolator stage.

---
 rtl/voice_phasor_scheduler.sv | 148 ++++++++++++++
 tb/tb_voice_phasor_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phasor_scheduler.sv
// voice_phasor_scheduler: time-multiplexed phase accumulator shared by
// NUM_VOICES synthesizer voices. Each sampleTick sweeps the voices in index
// order. Every gated voice produces a registered wavetable address and
// interpolation fraction, and its stored phase then advances by inc + fm.
//
// Output handshake: outValid is a one-cycle qualifier with no backpressure.
// outVoice, wavetableAddr and interp are meaningful only when outValid=1.
// They hold their last value otherwise. The consumer must accept every
// valid slot.
module voice_phasor_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sampleTick,
  input  logic              cfgWrite,
  input  logic [VIDX_W-1:0] cfgVoice,
  input  logic [31:0]       cfgIncrement,
  input  logic              cfgGate,
  input  logic [31:0]       fmInput,
  output logic [VIDX_W-1:0] sweepVoice,
  output logic              busy,
  output logic              outValid,
  output logic [VIDX_W-1:0] outVoice,
  output logic [11:0]       wavetableAddr,
  output logic [15:0]       interp,
  output logic              frameDone,
  output logic              overrun,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

  logic [0:0]        state_q, state_d;
  logic [VIDX_W-1:0] vidx_q, vidx_d;
  logic [31:0]       phase_q [NUM_VOICES];
  logic [31:0]       phase_d [NUM_VOICES];
  logic [31:0]       inc_q   [NUM_VOICES];
  logic [31:0]       inc_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic              out_valid_q, out_valid_d;
  logic [VIDX_W-1:0] out_voice_q, out_voice_d;
  logic [11:0]       addr_q, addr_d;
  logic [15:0]       interp_q, interp_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              sweeping;

  assign sweeping      = (state_q == ST_SWEEP);
  assign busy          = sweeping;
  assign sweepVoice    = sweeping ? vidx_q : '0;
  assign outValid      = out_valid_q;
  assign outVoice      = out_voice_q;
  assign wavetableAddr = addr_q;
  assign interp        = interp_q;
  assign frameDone     = frame_done_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

  // Next-state: sweep sequencing, config writes, then voice processing.
  // Processing is evaluated last so its phase update wins over a retrigger.
  always_comb begin
    state_d      = state_q;
    vidx_d       = vidx_q;
    phase_d      = phase_q;
    inc_d        = inc_q;
    gate_d       = gate_q;
    out_valid_d  = 1'b0;
    out_voice_d  = out_voice_q;
    addr_d       = addr_q;
    interp_d     = interp_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        vidx_d = '0;
        if (sampleTick) state_d = ST_SWEEP;
      end
      default: begin
        if (sampleTick) overrun_d = 1'b1;
        if (vidx_q == LAST_VOICE) begin
          state_d      = ST_IDLE;
          vidx_d       = '0;
          frame_done_d = 1'b1;
        end else begin
          vidx_d = vidx_q + VIDX_W'(1);
        end
      end
    endcase

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (cfgWrite && (cfgVoice == VIDX_W'(v))) begin
        inc_d[v]  = cfgIncrement;
        gate_d[v] = cfgGate;
        if (!gate_q[v] && cfgGate) phase_d[v] = '0;
      end
    end

    // Uses the pre-write inc/gate so a same-cycle write lands next sweep.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (sweeping && (vidx_q == VIDX_W'(v)) && gate_q[v]) begin
        out_valid_d = 1'b1;
        out_voice_d = VIDX_W'(v);
        addr_d      = phase_q[v][31:20];
        interp_d    = phase_q[v][19:4];
        phase_d[v]  = phase_q[v] + inc_q[v] + fmInput;
      end
    end
  end

  // State and output registers. Reset clears all voice state and outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      vidx_q       <= '0;
      gate_q       <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      addr_q       <= '0;
      interp_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      vidx_q       <= vidx_d;
      gate_q       <= gate_d;
      out_valid_q  <= out_valid_d;
      out_voice_q  <= out_voice_d;
      addr_q       <= addr_d;
      interp_q     <= interp_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= phase_d[v];
        inc_q[v]   <= inc_d[v];
      end
    end
  end

endmodule

// File: tb/tb_voice_phasor_scheduler.sv
// Directed bench for voice_phasor_scheduler with NUM_VOICES=4.
// Inputs change and outputs are sampled on the falling clock edge.
// A sweep capture records outputs for six cycles after the tick cycle T.
// Index c holds the values visible during cycle T+c.
module tb_voice_phasor_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        sampleTick;
  logic        cfgWrite;
  logic [1:0]  cfgVoice;
  logic [31:0] cfgIncrement;
  logic        cfgGate;
  logic [31:0] fmInput;
  logic [1:0]  sweepVoice;
  logic        busy;
  logic        outValid;
  logic [1:0]  outVoice;
  logic [11:0] wavetableAddr;
  logic [15:0] interp;
  logic        frameDone;
  logic        overrun;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic        cap_valid  [1:6];
  logic [1:0]  cap_voice  [1:6];
  logic [11:0] cap_addr   [1:6];
  logic [15:0] cap_interp [1:6];
  logic        cap_busy   [1:6];
  logic        cap_fd     [1:6];
  logic        cap_ovr    [1:6];
  logic [1:0]  cap_sv     [1:6];

  voice_phasor_scheduler #(.NUM_VOICES(4)) dut (
    .Clk(Clk), .Reset(Reset), .sampleTick(sampleTick), .cfgWrite(cfgWrite),
    .cfgVoice(cfgVoice), .cfgIncrement(cfgIncrement), .cfgGate(cfgGate),
    .fmInput(fmInput), .sweepVoice(sweepVoice), .busy(busy),
    .outValid(outValid), .outVoice(outVoice), .wavetableAddr(wavetableAddr),
    .interp(interp), .frameDone(frameDone), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic do_reset();
    Reset = 1'b1; sampleTick = 1'b0; cfgWrite = 1'b0; fmInput = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // driver tasks
  task automatic write_cfg(input logic [1:0] v, input logic [31:0] inc, input logic g);
    cfgWrite = 1'b1; cfgVoice = v; cfgIncrement = inc; cfgGate = g;
    @(negedge Clk);
    cfgWrite = 1'b0;
  endtask

  // Optional tick at T (current cycle), extra tick at T+tick2_c,
  // config write at T+wr_c, reset at T+rst_c; -1 disables an event.
  task automatic run_sweep(input bit start_tick, input int tick2_c, input int wr_c,
                           input logic [1:0] wr_v, input logic [31:0] wr_inc,
                           input logic wr_g, input int rst_c);
    sampleTick = start_tick;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      cap_valid[c] = outValid;  cap_voice[c] = outVoice;
      cap_addr[c] = wavetableAddr; cap_interp[c] = interp;
      cap_busy[c] = busy; cap_fd[c] = frameDone;
      cap_ovr[c] = overrun; cap_sv[c] = sweepVoice;
      sampleTick = (c == tick2_c);
      cfgWrite   = (c == wr_c);
      if (c == wr_c) begin
        cfgVoice = wr_v; cfgIncrement = wr_inc; cfgGate = wr_g;
      end
      Reset = (c == rst_c);
    end
  endtask

  task automatic plain_sweep();
    run_sweep(1'b1, -1, -1, 2'd0, 32'h0, 1'b0, -1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", outValid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone got %b exp 0", frameDone); end
    checks++; if ({wavetableAddr, interp, outVoice, sweepVoice} !== 32'h0) begin errors++; $display("FAIL reset_outputs got addr %h interp %h voice %0d sv %0d exp all 0", wavetableAddr, interp, outVoice, sweepVoice); end
  endtask

  task automatic test_basic_advance();
    logic [11:0] exp_addr;
    do_reset();
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      plain_sweep();
      exp_addr = 12'(s);
      checks++; if (cap_addr[2] !== exp_addr || cap_interp[2] !== 16'h0) begin errors++; $display("FAIL basic_addr sweep %0d got %h/%h exp %h/0000", s, cap_addr[2], cap_interp[2], exp_addr); end
      checks++; if ({cap_valid[1], cap_valid[2], cap_valid[3], cap_valid[4], cap_valid[5]} !== 5'b01000) begin errors++; $display("FAIL basic_valid_shape sweep %0d got %b%b%b%b%b exp 01000", s, cap_valid[1], cap_valid[2], cap_valid[3], cap_valid[4], cap_valid[5]); end
      checks++; if ({cap_fd[4], cap_fd[5], cap_fd[6]} !== 3'b010) begin errors++; $display("FAIL basic_framedone sweep %0d got %b%b%b exp 010", s, cap_fd[4], cap_fd[5], cap_fd[6]); end
    end
  endtask

  task automatic test_fraction();
    do_reset();
    write_cfg(2'd0, 32'h0000_8000, 1'b1);
    plain_sweep();
    plain_sweep();
    checks++; if (cap_addr[2] !== 12'h000 || cap_interp[2] !== 16'h0800) begin errors++; $display("FAIL frac_nofm got %h/%h exp 000/0800", cap_addr[2], cap_interp[2]); end
    do_reset();
    write_cfg(2'd0, 32'h0000_8000, 1'b1);
    fmInput = 32'h0000_8000;
    plain_sweep();
    plain_sweep();
    checks++; if (cap_addr[2] !== 12'h000 || cap_interp[2] !== 16'h1000) begin errors++; $display("FAIL frac_fm got %h/%h exp 000/1000", cap_addr[2], cap_interp[2]); end
    fmInput = '0;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [3];
    exp_addr[0] = 12'h000; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'hFFE;
    do_reset();
    write_cfg(2'd0, 32'hFFF0_0000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      plain_sweep();
      checks++; if (cap_valid[2] !== 1'b1 || cap_addr[2] !== exp_addr[s]) begin errors++; $display("FAIL wrap_addr sweep %0d got v%b %h exp v1 %h", s, cap_valid[2], cap_addr[2], exp_addr[s]); end
    end
    checks++; if (cap_ovr[6] !== 1'b0 || cap_fd[5] !== 1'b1) begin errors++; $display("FAIL wrap_flags got ovr %b fd %b exp 0 1", cap_ovr[6], cap_fd[5]); end
  endtask

  task automatic test_gated_sweep();
    logic [5:0] exp_valid, exp_busy, exp_fd;
    exp_valid = 6'b001010; exp_busy = 6'b001111; exp_fd = 6'b010000;
    do_reset();
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    write_cfg(2'd2, 32'h0020_0000, 1'b1);
    plain_sweep();
    for (int c = 1; c <= 6; c++) begin
      checks++; if (cap_valid[c] !== exp_valid[c-1] || cap_busy[c] !== exp_busy[c-1] || cap_fd[c] !== exp_fd[c-1]) begin errors++; $display("FAIL gated_shape T+%0d got v%b b%b fd%b exp v%b b%b fd%b", c, cap_valid[c], cap_busy[c], cap_fd[c], exp_valid[c-1], exp_busy[c-1], exp_fd[c-1]); end
    end
    for (int c = 1; c <= 4; c++) begin
      checks++; if (cap_sv[c] !== 2'(c - 1)) begin errors++; $display("FAIL gated_sweepvoice T+%0d got %0d exp %0d", c, cap_sv[c], c - 1); end
    end
    checks++; if (cap_voice[2] !== 2'd0 || cap_voice[4] !== 2'd2 || cap_voice[3] !== 2'd0) begin errors++; $display("FAIL gated_outvoice got %0d %0d %0d exp 0 0 2", cap_voice[2], cap_voice[3], cap_voice[4]); end
    plain_sweep();
    checks++; if (cap_addr[2] !== 12'h001 || cap_addr[4] !== 12'h002) begin errors++; $display("FAIL gated_second_addr got %h %h exp 001 002", cap_addr[2], cap_addr[4]); end
  endtask

  task automatic test_overrun();
    do_reset();
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    run_sweep(1'b1, 3, -1, 2'd0, 32'h0, 1'b0, -1);
    checks++; if (cap_ovr[3] !== 1'b0 || cap_ovr[4] !== 1'b1) begin errors++; $display("FAIL overrun_set got %b%b exp 01", cap_ovr[3], cap_ovr[4]); end
    checks++; if (cap_busy[5] !== 1'b0 || cap_fd[5] !== 1'b1 || cap_busy[6] !== 1'b0) begin errors++; $display("FAIL overrun_ignored got b%b fd%b b6%b exp 0 1 0", cap_busy[5], cap_fd[5], cap_busy[6]); end
    run_sweep(1'b1, 5, -1, 2'd0, 32'h0, 1'b0, -1);
    checks++; if (cap_addr[2] !== 12'h001 || cap_busy[6] !== 1'b1 || cap_sv[6] !== 2'd0) begin errors++; $display("FAIL overrun_t5_start got a%h b%b sv%0d exp 001 1 0", cap_addr[2], cap_busy[6], cap_sv[6]); end
    run_sweep(1'b0, -1, -1, 2'd0, 32'h0, 1'b0, -1);
    checks++; if (cap_valid[1] !== 1'b1 || cap_addr[1] !== 12'h002 || cap_fd[4] !== 1'b1) begin errors++; $display("FAIL overrun_t5_output got v%b a%h fd%b exp 1 002 1", cap_valid[1], cap_addr[1], cap_fd[4]); end
    checks++; if (cap_ovr[6] !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", cap_ovr[6]); end
  endtask

  task automatic test_reset_mid_sweep();
    // Continues from test_overrun: voice0 phase is 0x0030_0000, overrun set.
    run_sweep(1'b1, -1, -1, 2'd0, 32'h0, 1'b0, 2);
    checks++; if (cap_valid[2] !== 1'b1 || cap_addr[2] !== 12'h003) begin errors++; $display("FAIL midreset_pre got v%b a%h exp 1 003", cap_valid[2], cap_addr[2]); end
    checks++; if (cap_busy[3] !== 1'b0 || cap_valid[3] !== 1'b0 || cap_ovr[3] !== 1'b0 || cap_fd[3] !== 1'b0) begin errors++; $display("FAIL midreset_flags got b%b v%b o%b fd%b exp 0 0 0 0", cap_busy[3], cap_valid[3], cap_ovr[3], cap_fd[3]); end
    checks++; if (cap_addr[3] !== 12'h0 || cap_interp[3] !== 16'h0 || cap_voice[3] !== 2'd0 || cap_sv[3] !== 2'd0) begin errors++; $display("FAIL midreset_outputs got a%h i%h v%0d sv%0d exp 0", cap_addr[3], cap_interp[3], cap_voice[3], cap_sv[3]); end
    plain_sweep();
    checks++; if (cap_busy[1] !== 1'b1 || cap_valid[2] !== 1'b0) begin errors++; $display("FAIL midreset_gates_cleared got b%b v%b exp 1 0", cap_busy[1], cap_valid[2]); end
  endtask

  task automatic test_collision();
    do_reset();
    write_cfg(2'd1, 32'h0010_0000, 1'b1);
    run_sweep(1'b1, -1, 2, 2'd1, 32'h0030_0000, 1'b1, -1);
    checks++; if (cap_valid[3] !== 1'b1 || cap_voice[3] !== 2'd1 || cap_addr[3] !== 12'h000) begin errors++; $display("FAIL collide_first got v%b vo%0d a%h exp 1 1 000", cap_valid[3], cap_voice[3], cap_addr[3]); end
    plain_sweep();
    checks++; if (cap_addr[3] !== 12'h001) begin errors++; $display("FAIL collide_old_inc got %h exp 001", cap_addr[3]); end
    plain_sweep();
    checks++; if (cap_addr[3] !== 12'h004) begin errors++; $display("FAIL collide_new_inc got %h exp 004", cap_addr[3]); end
  endtask

  task automatic test_retrigger();
    do_reset();
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    plain_sweep();
    plain_sweep();
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    plain_sweep();
    checks++; if (cap_addr[2] !== 12'h002) begin errors++; $display("FAIL retrig_1to1 got %h exp 002", cap_addr[2]); end
    write_cfg(2'd0, 32'h0010_0000, 1'b0);
    plain_sweep();
    checks++; if (cap_valid[2] !== 1'b0 || cap_addr[2] !== 12'h002) begin errors++; $display("FAIL retrig_gated_off got v%b a%h exp 0 002", cap_valid[2], cap_addr[2]); end
    write_cfg(2'd0, 32'h0010_0000, 1'b1);
    plain_sweep();
    checks++; if (cap_valid[2] !== 1'b1 || cap_addr[2] !== 12'h000) begin errors++; $display("FAIL retrig_0to1 got v%b a%h exp 1 000", cap_valid[2], cap_addr[2]); end
  endtask

  // sequence and final report
  initial begin
    Reset = 1'b1; sampleTick = 1'b0; cfgWrite = 1'b0; cfgVoice = '0;
    cfgIncrement = '0; cfgGate = 1'b0; fmInput = '0;
    @(negedge Clk);
    test_reset();
    test_basic_advance();
    test_fraction();
    test_wrap();
    test_gated_sweep();
    test_overrun();
    test_reset_mid_sweep();
    test_collision();
    test_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
